program_loader: RTL and testbench
=================================

# program_loader

Streams a MIPS program into the CPU's instruction memory over a byte-wide valid/ready link and releases the CPU once the image has been checked. It sits directly upstream of the CPU and its InstructionMemory, replacing the simulation-only `$readmemb` fill with a synthesizable load path. It frames the byte stream, assembles big-endian words, writes them to sequential word addresses and verifies an XOR checksum. It then either raises `cpu_run` or latches an error.

## Interface
- `INSTR_MEM_SIZE`, default 32: instruction memory depth in words; legal range 1..65535.
- `ADDR_WIDTH`, default 5: word-address width; 2^ADDR_WIDTH >= INSTR_MEM_SIZE required.
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  upstream byte valid.
- `in_byte`  in  8  upstream byte.
- `in_ready`  out  1  loader can accept a byte.
- `imem_we`  out  1  one-cycle instruction-memory write strobe.
- `imem_addr`  out  ADDR_WIDTH  word address of the write.
- `imem_wdata`  out  32  word to write.
- `cpu_run`  out  1  CPU may leave reset; high from DONE onward.
- `load_done`  out  1  image accepted.
- `load_error`  out  1  image rejected.

## Operation
- Handshake:
  - A byte transfers on a rising edge where `in_valid && in_ready`.
  - Upstream may hold `in_valid` low arbitrarily between bytes.
  - `in_byte` is sampled only on a transfer.
- Frame format:
  - LEN_HI and LEN_LO bytes carry a 16-bit word count N.
  - Then N words of 4 bytes each, most-significant byte first.
  - Then one checksum byte equal to the XOR of all 4N data bytes. The length bytes are excluded.
- States:
  - LEN: byte counter 0..1, builds N. After LEN_LO, N==0 or N>INSTR_MEM_SIZE → ERROR; otherwise → DATA.
  - DATA: byte counter 0..3 and word counter 0..N-1. Every data byte is XORed into the running checksum. The 4th byte of a word issues a write to address = word counter, then increments the word counter. The 4th byte of word N-1 → CSUM.
  - CSUM: one byte. Equal to the running XOR → DONE; else → ERROR.
  - DONE: terminal until reset. `load_done`=1, `cpu_run`=1.
  - ERROR: terminal until reset. `load_error`=1, `cpu_run`=0.
- `in_ready` = 1 in LEN, DATA and CSUM while `reset` is low; 0 in DONE, ERROR, and in any cycle with `reset` high.
- Memory addresses ≥ N are never written. A rejected image may leave partial writes; `cpu_run` stays 0 in that case.
- Reset mid-operation:
  - On the reset edge: state → LEN; all counters and the checksum clear; `imem_we`, `cpu_run`, `load_done` and `load_error` → 0.
  - Memory contents are left as they are.

## Timing
- Reset values of outputs:
  - `in_ready`=0 during reset, 1 in the first cycle after.
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `cpu_run`=0, `load_done`=0, `load_error`=0.
- Write latency:
  - The 4th byte of a word transfers at edge k.
  - `imem_we`=1 with valid `imem_addr`/`imem_wdata` during the cycle after k.
  - `imem_we` drops at edge k+1. It is a single-cycle pulse, because the next write needs ≥4 further transfers.
  - `imem_addr`/`imem_wdata` hold their last values while `imem_we`=0.
- Completion:
  - The checksum byte transfers at edge m.
  - During the cycle after m, `cpu_run`/`load_done` (or `load_error`) are already 1 and `in_ready`=0.
- Length error: flagged in the cycle after the LEN_LO transfer edge.
- Throughput: one byte per cycle maximum. A full image takes 2+4N+1 transfers.

## Test plan
- Valid load, `in_valid` held high:
  - Bytes 00 02 20 08 00 05 01 08 40 20 44.
  - Required: writes addr0=0x20080005 and addr1=0x01084020, one cycle after the 6th and 10th transfers.
  - Required: `cpu_run`=`load_done`=1 one cycle after the 11th transfer.
- Same stream with `in_valid` low for 3 cycles between every byte → identical writes and flags. No `imem_we` occurs except after a 4th byte.
- Length 00 00 → `load_error`=1 after the 2nd transfer, `in_ready`=0, no write ever.
- Length 00 21 (33 > 32) → same as the length-0 case.
- Valid 2-word stream but checksum 0x45 → both writes occur, then `load_error`=1 and `cpu_run`=0.
- Reset held one cycle after the 7th transfer, then the valid 11-byte stream is sent:
  - Required: the post-reset stream loads correctly from addr0 and ends in DONE.
  - Required: all outputs were 0 in the cycle following the reset edge.

Source files
------------

// File: rtl/program_loader_if.sv
// ----------------------------------------------------------------------------
// program_loader_if
//   Groups the signals between the program loader, its byte source and the
//   instruction memory / CPU release lines.
//   Signals:
//     in_valid, in_byte : upstream byte stream (source -> loader)
//     in_ready          : loader can accept a byte (loader -> source)
//     imem_we           : one-cycle instruction-memory write strobe
//     imem_addr         : word address of the write
//     imem_wdata        : 32-bit word to write
//     cpu_run           : CPU may leave reset
//     load_done         : image accepted
//     load_error        : image rejected
//   Modports:
//     slave  : loader side
//     master : source / environment side
// ----------------------------------------------------------------------------
interface program_loader_if #(
    parameter int ADDR_WIDTH = 5
) ();
    logic                  in_valid;
    logic [7:0]            in_byte;
    logic                  in_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  cpu_run;
    logic                  load_done;
    logic                  load_error;

    modport slave (
        input  in_valid,
        input  in_byte,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata,
        output cpu_run,
        output load_done,
        output load_error
    );

    modport master (
        output in_valid,
        output in_byte,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata,
        input  cpu_run,
        input  load_done,
        input  load_error
    );
endinterface

// File: rtl/program_loader.sv
// ----------------------------------------------------------------------------
// program_loader
//   Receives a framed MIPS program image over a byte-wide valid/ready link,
//   writes it word by word into instruction memory and releases the CPU once
//   the trailing XOR checksum matches.
//   Frame: LEN_HI, LEN_LO (word count N), 4N data bytes (big-endian words),
//   one checksum byte = XOR of all data bytes.
//   Ports:
//     clock : single rising-edge clock
//     reset : synchronous, active-high
//     bus   : program_loader_if.slave (stream in, memory write, status out)
//   Parameters:
//     INSTR_MEM_SIZE : instruction memory depth in words (1..65535)
//     ADDR_WIDTH     : word address width, 2**ADDR_WIDTH >= INSTR_MEM_SIZE
// ----------------------------------------------------------------------------
module program_loader #(
    parameter int INSTR_MEM_SIZE = 32,
    parameter int ADDR_WIDTH     = 5
) (
    input  logic              clock,
    input  logic              reset,
    program_loader_if.slave   bus
);

    localparam logic [15:0] MAX_WORDS = 16'(INSTR_MEM_SIZE);

    typedef enum logic [2:0] {
        S_LEN   = 3'd0,
        S_DATA  = 3'd1,
        S_CSUM  = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t                state_q,      state_d;
    logic [1:0]            byte_cnt_q,   byte_cnt_d;
    logic [15:0]           word_cnt_q,   word_cnt_d;
    logic [15:0]           len_q,        len_d;
    logic [7:0]            csum_q,       csum_d;
    logic [23:0]           shift_q,      shift_d;
    logic                  imem_we_q,    imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q,  imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;

    logic                  accepting;
    logic                  xfer;
    logic [15:0]           len_rx;

    // Ready is combinational on reset so no byte is consumed on a reset edge.
    assign accepting = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign xfer      = bus.in_valid && accepting && !reset;
    // Word count as it stands once LEN_LO arrives.
    assign len_rx    = {len_q[15:8], bus.in_byte};

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_cnt_d   = word_cnt_q;
        len_d        = len_q;
        csum_d       = csum_q;
        shift_d      = shift_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        if (xfer) begin
            unique case (state_q)
                S_LEN: begin
                    if (byte_cnt_q == 2'd0) begin
                        len_d[15:8] = bus.in_byte;
                        byte_cnt_d  = 2'd1;
                    end else begin
                        len_d      = len_rx;
                        byte_cnt_d = 2'd0;
                        if ((len_rx == 16'd0) || (len_rx > MAX_WORDS)) begin
                            state_d = S_ERROR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    csum_d = csum_q ^ bus.in_byte;
                    if (byte_cnt_q != 2'd3) begin
                        shift_d    = {shift_q[15:0], bus.in_byte};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end else begin
                        // Fourth byte completes the word: issue the write now.
                        imem_we_d    = 1'b1;
                        imem_addr_d  = ADDR_WIDTH'(word_cnt_q);
                        imem_wdata_d = {shift_q, bus.in_byte};
                        byte_cnt_d   = 2'd0;
                        word_cnt_d   = word_cnt_q + 16'd1;
                        if (word_cnt_q == (len_q - 16'd1)) begin
                            state_d = S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (bus.in_byte == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_LEN;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            len_q        <= '0;
            csum_q       <= '0;
            shift_q      <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            len_q        <= len_d;
            csum_q       <= csum_d;
            shift_q      <= shift_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
        end
    end

    assign bus.in_ready   = accepting && !reset;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.cpu_run    = (state_q == S_DONE);
    assign bus.load_done  = (state_q == S_DONE);
    assign bus.load_error = (state_q == S_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// ----------------------------------------------------------------------------
// tb_program_loader
//   Directed bench for program_loader. A frame-level model derives the
//   expected outputs from the list of bytes accepted so far; a compare
//   process checks every cycle, and literal checks pin key results.
// ----------------------------------------------------------------------------
module tb_program_loader;

    logic clock;
    logic reset;

    program_loader_if #(.ADDR_WIDTH(5)) bus_if ();

    program_loader #(.INSTR_MEM_SIZE(32), .ADDR_WIDTH(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- frame-level model ----------------
    logic [7:0]  mb[$];
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_wdata;
    bit          seen_reset = 0;

    // 0 = still loading, 1 = accepted, 2 = rejected
    function automatic int status();
        int t;
        int n;
        logic [7:0] x;
        t = mb.size();
        if (t < 2) return 0;
        n = {mb[0], mb[1]};
        if (n == 0 || n > 32) return 2;
        if (t < 3 + 4 * n) return 0;
        x = 8'h00;
        for (int i = 2; i < 2 + 4 * n; i++) x = x ^ mb[i];
        return (x == mb[2 + 4 * n]) ? 1 : 2;
    endfunction

    always @(posedge clock) begin
        int t;
        int n;
        if (reset) begin
            mb.delete();
            exp_we     = 1'b0;
            exp_addr   = '0;
            exp_wdata  = '0;
            seen_reset = 1;
        end else begin
            exp_we = 1'b0;
            if (bus_if.in_valid === 1'b1 && status() == 0) begin
                mb.push_back(bus_if.in_byte);
                t = mb.size();
                if (t >= 6) begin
                    n = {mb[0], mb[1]};
                    if (n >= 1 && n <= 32 && ((t - 2) % 4 == 0) && t <= 2 + 4 * n) begin
                        exp_we    = 1'b1;
                        exp_addr  = 5'((t - 6) / 4);
                        exp_wdata = {mb[t-4], mb[t-3], mb[t-2], mb[t-1]};
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare and write log ----------------
    logic [4:0]  log_addr[$];
    logic [31:0] log_data[$];

    always @(negedge clock) begin
        int st;
        if (seen_reset) begin
            st = status();
            chk("in_ready",   {31'd0, bus_if.in_ready},   {31'd0, (!reset && st == 0)});
            chk("imem_we",    {31'd0, bus_if.imem_we},    {31'd0, exp_we});
            chk("imem_addr",  {27'd0, bus_if.imem_addr},  {27'd0, exp_addr});
            chk("imem_wdata", bus_if.imem_wdata,          exp_wdata);
            chk("cpu_run",    {31'd0, bus_if.cpu_run},    {31'd0, (st == 1)});
            chk("load_done",  {31'd0, bus_if.load_done},  {31'd0, (st == 1)});
            chk("load_error", {31'd0, bus_if.load_error}, {31'd0, (st == 2)});
            if (bus_if.imem_we === 1'b1) begin
                log_addr.push_back(bus_if.imem_addr);
                log_data.push_back(bus_if.imem_wdata);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] stim[$];

    task automatic send(input logic [7:0] b, input int gap);
        int w;
        w = 0;
        bus_if.in_valid = 1'b1;
        bus_if.in_byte  = b;
        @(negedge clock);
        while (bus_if.in_ready !== 1'b1 && w < 20) begin
            @(negedge clock);
            w++;
        end
        if (w >= 20) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=in_ready_low required=accept byte %0h", b);
            bus_if.in_valid = 1'b0;
        end else begin
            @(posedge clock);
            #2;
            bus_if.in_valid = 1'b0;
            bus_if.in_byte  = ~b;
            repeat (gap) @(posedge clock);
            if (gap > 0) #2;
        end
    endtask

    task automatic send_stim(input int gap);
        foreach (stim[i]) send(stim[i], gap);
    endtask

    task automatic do_reset();
        bus_if.in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic settle();
        repeat (4) @(posedge clock);
        #2;
    endtask

    task automatic check_good_load(input string tag);
        chk({tag, "_nwrites"}, 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            chk({tag, "_addr0"}, {27'd0, log_addr[0]}, 32'd0);
            chk({tag, "_data0"}, log_data[0], 32'h20080005);
            chk({tag, "_addr1"}, {27'd0, log_addr[1]}, 32'd1);
            chk({tag, "_data1"}, log_data[1], 32'h01084020);
        end
        chk({tag, "_cpu_run"},   {31'd0, bus_if.cpu_run},    32'd1);
        chk({tag, "_load_done"}, {31'd0, bus_if.load_done},  32'd1);
        chk({tag, "_load_err"},  {31'd0, bus_if.load_error}, 32'd0);
        chk({tag, "_in_ready"},  {31'd0, bus_if.in_ready},   32'd0);
    endtask

    initial begin
        reset           = 1'b1;
        bus_if.in_valid = 1'b0;
        bus_if.in_byte  = 8'h00;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready_low", {31'd0, bus_if.in_ready}, 32'd0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_in_ready_after", {31'd0, bus_if.in_ready}, 32'd1);
        chk("rst_imem_we",   {31'd0, bus_if.imem_we}, 32'd0);
        chk("rst_imem_addr", {27'd0, bus_if.imem_addr}, 32'd0);
        chk("rst_imem_wdata", bus_if.imem_wdata, 32'd0);
        chk("rst_cpu_run",   {31'd0, bus_if.cpu_run}, 32'd0);

        stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                 8'h01, 8'h08, 8'h40, 8'h20, 8'h44};

        // Valid load, back-to-back
        do_reset();
        send_stim(0);
        settle();
        check_good_load("t1");

        // Valid load with idle gaps
        do_reset();
        send_stim(3);
        settle();
        check_good_load("t2");

        // Length zero
        do_reset();
        send(8'h00, 0);
        send(8'h00, 0);
        settle();
        chk("len0_error",   {31'd0, bus_if.load_error}, 32'd1);
        chk("len0_ready",   {31'd0, bus_if.in_ready},   32'd0);
        chk("len0_run",     {31'd0, bus_if.cpu_run},    32'd0);
        chk("len0_nwrites", 32'(log_addr.size()), 32'd0);

        // Length over capacity
        do_reset();
        send(8'h00, 0);
        send(8'h21, 0);
        settle();
        chk("len33_error",   {31'd0, bus_if.load_error}, 32'd1);
        chk("len33_ready",   {31'd0, bus_if.in_ready},   32'd0);
        chk("len33_nwrites", 32'(log_addr.size()), 32'd0);

        // Bad checksum
        do_reset();
        stim[10] = 8'h45;
        send_stim(0);
        settle();
        chk("csum_nwrites", 32'(log_addr.size()), 32'd2);
        chk("csum_error",   {31'd0, bus_if.load_error}, 32'd1);
        chk("csum_run",     {31'd0, bus_if.cpu_run},    32'd0);
        chk("csum_done",    {31'd0, bus_if.load_done},  32'd0);
        stim[10] = 8'h44;

        // Reset after the 7th transfer, then a full load
        do_reset();
        for (int i = 0; i < 7; i++) send(stim[i], 0);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_ready_low", {31'd0, bus_if.in_ready}, 32'd0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        log_addr.delete();
        log_data.delete();
        @(negedge clock);
        chk("mid_rst_we",     {31'd0, bus_if.imem_we},    32'd0);
        chk("mid_rst_addr",   {27'd0, bus_if.imem_addr},  32'd0);
        chk("mid_rst_wdata",  bus_if.imem_wdata,          32'd0);
        chk("mid_rst_run",    {31'd0, bus_if.cpu_run},    32'd0);
        chk("mid_rst_done",   {31'd0, bus_if.load_done},  32'd0);
        chk("mid_rst_err",    {31'd0, bus_if.load_error}, 32'd0);
        @(posedge clock);
        #2;
        send_stim(0);
        settle();
        check_good_load("t7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
